// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 (LCD1602) write path: writer FSM states,
// default 50 MHz bus timing and the controller command codes used by the sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_wr_state_t;

    // Default timing in 50 MHz cycles
    localparam int LCD_T_SETUP = 4;
    localparam int LCD_T_EN    = 16;
    localparam int LCD_T_HOLD  = 4;
    localparam int LCD_T_EXEC  = 2000;
    localparam int LCD_T_LONG  = 82000;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear/home (0x01..0x03 decode to them) need the long execution wait; data writes never do
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Load/decrement down-counter with a zero flag; stops at zero and never wraps.
// Shared by the byte writer phases and the sequencer power-on delay.
module lcd_delay_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 bus-timing engine: drives one byte with setup / EN pulse / hold timing,
// then waits out the controller execution time before pulsing odone.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = LCD_T_SETUP,
    parameter int T_EN    = LCD_T_EN,
    parameter int T_HOLD  = LCD_T_HOLD,
    parameter int T_EXEC  = LCD_T_EXEC,
    parameter int T_LONG  = LCD_T_LONG
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic [7:0] idata,
    input  logic       irs,
    input  logic       istart,
    output logic       obusy,
    output logic       odone,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    // Wide enough for every phase length, so the constant loads below cannot truncate
    localparam int CW = $clog2(max_int(max_int(T_LONG, T_EXEC),
                                       max_int(T_EN, max_int(T_SETUP, T_HOLD))) + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);

    if (T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 || T_EXEC < 1 || T_LONG < 1) begin : g_bad_timing
        $error("lcd_byte_writer: all timing parameters must be >= 1");
    end

    lcd_wr_state_t state, state_nxt;
    logic          long_q, long_nxt;
    logic [7:0]    data_nxt;
    logic          rs_nxt, en_nxt, busy_nxt, done_nxt;
    logic          cnt_load, cnt_zero;
    logic [CW-1:0] cnt_load_val;

    lcd_delay_cnt #(.CW(CW)) u_cnt (
        .clk      (iclk),
        .rst_n    (irst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_nxt    = state;
        long_nxt     = long_q;
        data_nxt     = LCD_DATA;
        rs_nxt       = LCD_RS;
        en_nxt       = LCD_EN;
        busy_nxt     = obusy;
        done_nxt     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state)
            IDLE: begin
                if (istart) begin
                    state_nxt    = SETUP;
                    data_nxt     = idata;
                    rs_nxt       = irs;
                    busy_nxt     = 1'b1;
                    long_nxt     = is_long_cmd(irs, idata);
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt    = PULSE;
                    en_nxt       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_EN;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_nxt    = HOLD;
                    en_nxt       = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_HOLD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt    = WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = long_q ? LD_LONG : LD_EXEC;
                end
            end
            WAIT: begin
                // Bus keeps its last value; only busy/done change on exit
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state    <= IDLE;
            long_q   <= 1'b0;
            LCD_DATA <= '0;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
            obusy    <= 1'b0;
            odone    <= 1'b0;
        end else begin
            state    <= state_nxt;
            long_q   <= long_nxt;
            LCD_DATA <= data_nxt;
            LCD_RS   <= rs_nxt;
            LCD_EN   <= en_nxt;
            obusy    <= busy_nxt;
            odone    <= done_nxt;
        end
    end

    assign LCD_RW = 1'b0;

endmodule
